// File: rtl/serial_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and a status word for the read mux.
// Optional even-parity bit when SERIAL_PARITY_EN is defined.
module serial_tx_mmio #(
  parameter int unsigned DIVISOR    = 434,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        tx,
  output logic        irq_empty
);

  localparam int unsigned CNT_W  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               irq_q, irq_d;
  logic               ovf_q, ovf_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]  count_q, count_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
`ifdef SERIAL_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic        wr_hit_c, st_hit_c, full_c, empty_c, baud_wrap_c, push_ok_c, pop_c;
  logic [7:0]  head_c;
  logic [31:0] status_c;
  logic        unused_c;

  assign wr_hit_c    = sel & we & (addr[3:2] == 2'd0);
  assign st_hit_c    = sel & we & (addr[3:2] == 2'd1);
  assign full_c      = (count_q == FIFO_FULL);
  assign empty_c     = (count_q == '0);
  assign baud_wrap_c = (baud_q == BAUD_LAST);
  assign push_ok_c   = wr_hit_c & ~full_c;
  assign head_c      = mem_q[rd_ptr_q];
  assign unused_c    = ^{addr[1:0], din[31:8]};

  // Frame sequencer: baud timing, bit shifting and FIFO pop decision.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_c   = 1'b0;
`ifdef SERIAL_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q != ST_IDLE) begin
      baud_d = baud_wrap_c ? '0 : baud_q + CNT_W'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (!empty_c) pop_c = 1'b1;
      end
      ST_START: begin
        if (baud_wrap_c) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (baud_wrap_c) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef SERIAL_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_PARITY_EN
      ST_PARITY: begin
        if (baud_wrap_c) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (baud_wrap_c) begin
          if (!empty_c) pop_c = 1'b1;
          else          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A pop always loads the head byte and starts a fresh frame with no idle gap.
    if (pop_c) begin
      state_d = ST_START;
      shift_d = head_c;
      baud_d  = '0;
      bit_d   = '0;
`ifdef SERIAL_PARITY_EN
      parity_d = ^head_c;
`endif
    end
  end

  // FIFO storage, pointers, count and sticky overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = din[7:0];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_hit_c && full_c)         ovf_d = 1'b1;
    else if (st_hit_c && din[3])    ovf_d = 1'b0;
    count_d = count_q + FCNT_W'(push_ok_c) - FCNT_W'(pop_c);
  end

  // Registered line level and interrupt follow the next state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
    irq_d = (count_d == '0) && (state_d == ST_IDLE);
  end

  always_comb begin
    status_c       = '0;
    status_c[0]    = full_c;
    status_c[1]    = empty_c;
    status_c[2]    = (state_q != ST_IDLE);
    status_c[3]    = ovf_q;
`ifdef SERIAL_PARITY_EN
    status_c[4]    = 1'b1;
`endif
    status_c[16:8] = 9'(count_q);
    dout           = addr[3] ? 32'h0 : status_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b1;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
`ifdef SERIAL_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
`ifdef SERIAL_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx        = tx_q;
  assign irq_empty = irq_q;

endmodule

// File: tb/tb_serial_tx_mmio.sv
// Self-checking bench for serial_tx_mmio: line monitor feeds a byte scoreboard,
// scenario tasks check status, latency, back-to-back framing, overflow and reset.
module tb_serial_tx_mmio;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef SERIAL_PARITY_EN
  localparam int          NBITS   = 11;
  localparam logic [31:0] ST_BASE = 32'h10;
`else
  localparam int          NBITS   = 10;
  localparam logic [31:0] ST_BASE = 32'h0;
`endif
  localparam int FRAME = NBITS * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic        tx;
  logic        irq_empty;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_rx = 0;
  logic [7:0] exp_q[$];
  int start_q[$];

  serial_tx_mmio #(.DIVISOR(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .we(we), .addr(addr),
    .din(din), .dout(dout), .tx(tx), .irq_empty(irq_empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef SERIAL_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Line monitor: samples mid-bit on the falling clock edge, scores each frame.
  initial begin : monitor
    logic [7:0] b;
    logic [7:0] e;
    int t;
    int j;
    bit act;
    act = 1'b0; t = 0; b = 8'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act = 1'b0;
      end else begin
        if (act) t++;
        else if (tx === 1'b0) begin
          act = 1'b1; t = 0; start_q.push_back(cyc);
        end
        if (act && (t % DIV) == DIV / 2) begin
          j = t / DIV;
          if (j == 0) begin
            checks++;
            if (tx !== 1'b0) begin errors++; $display("FAIL mon_start tx=%b want 0", tx); end
          end else if (j <= 8) begin
            b[j-1] = tx;
`ifdef SERIAL_PARITY_EN
          end else if (j == 9) begin
            checks++;
            if (tx !== ^b) begin errors++; $display("FAIL mon_parity tx=%b want %b", tx, ^b); end
`endif
          end
          if (j == NBITS - 1) begin
            checks++;
            if (tx !== 1'b1) begin errors++; $display("FAIL mon_stop tx=%b want 1", tx); end
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL mon_byte got %h want none", b);
            end else begin
              e = exp_q.pop_front();
              if (b !== e) begin errors++; $display("FAIL mon_byte got %h want %h", b, e); end
            end
            frames_rx++;
            act = 1'b0;
          end
        end
      end
    end
  end

  task automatic store(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; din = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; addr = 4'h0; din = 32'h0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int k = 0;
    while (frames_rx < n && k < budget) begin @(posedge clk); k++; end
    checks++;
    if (frames_rx < n) begin
      errors++; $display("FAIL %s_timeout frames=%0d want %0d", tag, frames_rx, n);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || dout !== (ST_BASE | 32'h2) || irq_empty !== 1'b1) begin
      errors++; $display("FAIL reset_async tx=%b dout=%h irq=%b want 1 %h 1", tx, dout, irq_empty, ST_BASE | 32'h2);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (tx !== 1'b1 || dout !== (ST_BASE | 32'h2) || irq_empty !== 1'b1) begin
        errors++; $display("FAIL reset_idle cyc%0d tx=%b dout=%h irq=%b", i, tx, dout, irq_empty);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single(input logic [7:0] b);
    int e;
    int base;
    base = frames_rx;
    exp_q.push_back(b);
    store(4'h0, {24'h0, b});
    checks++;
    if (tx !== 1'b1 || dout !== (ST_BASE | 32'h100) || irq_empty !== 1'b0) begin
      errors++; $display("FAIL single_queued tx=%b dout=%h irq=%b want 1 %h 0", tx, dout, irq_empty, ST_BASE | 32'h100);
    end
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b0 || dout !== (ST_BASE | 32'h6)) begin
      errors++; $display("FAIL single_latency tx=%b dout=%h want 0 %h", tx, dout, ST_BASE | 32'h6);
    end
    e = 0;
    for (int j = 0; j < NBITS; j++) begin
      repeat (4 * j + 2 - e) @(posedge clk);
      #1; e = 4 * j + 2;
      checks++;
      if (tx !== exp_bit(b, j)) begin
        errors++; $display("FAIL single_bit%0d tx=%b want %b", j, tx, exp_bit(b, j));
      end
    end
    repeat (FRAME - 1 - e) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || irq_empty !== 1'b0) begin
      errors++; $display("FAIL single_last_stop tx=%b irq=%b want 1 0", tx, irq_empty);
    end
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1 || irq_empty !== 1'b1 || dout !== (ST_BASE | 32'h2)) begin
      errors++; $display("FAIL single_end tx=%b irq=%b dout=%h want 1 1 %h", tx, irq_empty, dout, ST_BASE | 32'h2);
    end
    wait_frames(base + 1, 20, "single");
  endtask

  task automatic test_addr_map();
    addr = 4'h8; #1;
    checks++;
    if (dout !== 32'h0) begin errors++; $display("FAIL map_rd8 dout=%h want 0", dout); end
    addr = 4'hC; #1;
    checks++;
    if (dout !== 32'h0) begin errors++; $display("FAIL map_rdC dout=%h want 0", dout); end
    addr = 4'h7; #1;
    checks++;
    if (dout !== (ST_BASE | 32'h2)) begin errors++; $display("FAIL map_rd7 dout=%h want %h", dout, ST_BASE | 32'h2); end
    store(4'h8, 32'h41);
    store(4'hC, 32'h42);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (dout !== (ST_BASE | 32'h2) || tx !== 1'b1) begin
      errors++; $display("FAIL map_wr_ignored dout=%h tx=%b want %h 1", dout, tx, ST_BASE | 32'h2);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = frames_rx;
    start_q.delete();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    store(4'h0, 32'h11);
    store(4'h0, 32'h22);
    store(4'h0, 32'h33);
    checks++;
    if (dout !== (ST_BASE | 32'h204)) begin
      errors++; $display("FAIL b2b_count dout=%h want %h", dout, ST_BASE | 32'h204);
    end
    wait_frames(base + 3, 3 * FRAME + 20, "b2b");
    checks++;
    if (start_q.size() != 3) begin
      errors++; $display("FAIL b2b_starts got %0d want 3", start_q.size());
    end else begin
      if (start_q[1] - start_q[0] != FRAME || start_q[2] - start_q[1] != FRAME) begin
        errors++; $display("FAIL b2b_gap got %0d %0d want %0d", start_q[1] - start_q[0], start_q[2] - start_q[1], FRAME);
      end
    end
    repeat (4) @(posedge clk); #1;
    checks++;
    if (irq_empty !== 1'b1 || tx !== 1'b1) begin
      errors++; $display("FAIL b2b_idle irq=%b tx=%b want 1 1", irq_empty, tx);
    end
  endtask

  task automatic test_overflow();
    int base;
    base = frames_rx;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h61 + i));
    for (int i = 0; i < 6; i++) store(4'h0, 32'h61 + 32'(i));
    checks++;
    if (dout !== (ST_BASE | 32'h40D)) begin
      errors++; $display("FAIL ovf_set dout=%h want %h", dout, ST_BASE | 32'h40D);
    end
    store(4'h4, 32'hFFFF_FFF7);
    checks++;
    if (dout !== (ST_BASE | 32'h40D)) begin
      errors++; $display("FAIL ovf_keep dout=%h want %h", dout, ST_BASE | 32'h40D);
    end
    store(4'h4, 32'h8);
    checks++;
    if (dout !== (ST_BASE | 32'h405)) begin
      errors++; $display("FAIL ovf_clear dout=%h want %h", dout, ST_BASE | 32'h405);
    end
    wait_frames(base + 5, 5 * FRAME + 40, "ovf");
    repeat (2 * FRAME) @(posedge clk); #1;
    checks++;
    if (frames_rx != base + 5 || exp_q.size() != 0) begin
      errors++; $display("FAIL ovf_frames got %0d left %0d want 5 0", frames_rx - base, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bit bad;
    base = frames_rx;
    store(4'h0, 32'h55);
    store(4'h0, 32'h66);
    store(4'h0, 32'h77);
    repeat (8) @(posedge clk); #1;
    checks++;
    if (tx !== 1'b0 || dout !== (ST_BASE | 32'h204)) begin
      errors++; $display("FAIL rmid_pre tx=%b dout=%h want 0 %h", tx, dout, ST_BASE | 32'h204);
    end
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || irq_empty !== 1'b1) begin
      errors++; $display("FAIL rmid_async tx=%b irq=%b want 1 1", tx, irq_empty);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dout !== (ST_BASE | 32'h2)) begin
      errors++; $display("FAIL rmid_status dout=%h want %h", dout, ST_BASE | 32'h2);
    end
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (tx !== 1'b1) bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad || frames_rx != base) begin
      errors++; $display("FAIL rmid_quiet txlow=%0d frames=%0d want 0 0", bad, frames_rx - base);
    end
  endtask

`ifdef SERIAL_PARITY_EN
  task automatic test_parity();
    checks++;
    if (dout[4] !== 1'b1) begin errors++; $display("FAIL par_flag bit4=%b want 1", dout[4]); end
    test_single(8'h07);
  endtask
`endif

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single(8'hA5);
    test_addr_map();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
`ifdef SERIAL_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
